// File: rtl/aes_srow_stream.sv
// Column-serial ShiftRows / InvShiftRows for Rijndael blocks of NB = 4, 6 or 8 columns.
// Latency: first shifted column is valid the cycle after the last column of a block is accepted.
// Backpressure: ping-pong banks; in_ready drops only while both banks hold complete, undrained blocks.
module aes_srow_stream #(
    parameter int NB = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col,
    output logic        out_last
);

    // Rijndael only defines these three block widths.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_srow_stream: NB must be 4, 6 or 8");
    end

    localparam int CW = $clog2(NB);
    // Row offsets: only the 256-bit block uses the wider 1/3/4 pattern.
    localparam int C1 = 1;
    localparam int C2 = (NB == 8) ? 3 : 2;
    localparam int C3 = (NB == 8) ? 4 : 3;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [31:0]   bank [2][NB];
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic [1:0]    mode;
    logic          wr_bank;
    logic          rd_bank;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          in_fire;
    logic          out_fire;
    logic [31:0]   shifted;

    function automatic int row_ofs(input int r);
        case (r)
            1:       return C1;
            2:       return C2;
            3:       return C3;
            default: return 0;
        endcase
    endfunction

    // Source column for output column j of a row shifted by c; inverse rotates the other way.
    function automatic logic [CW-1:0] src_idx(input logic [CW-1:0] j, input int c, input logic inv);
        int t;
        t = inv ? (int'(j) + NB - c) : (int'(j) + c);
        if (t >= NB) t = t - NB;
        return t[CW-1:0];
    endfunction

    // Handshake qualifiers: both derive only from registered bank state.
    always_comb begin
        in_ready  = !full[wr_bank];
        out_valid = full[rd_bank];
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    // Store each accepted column in the filling bank.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NB; c++) begin
                    bank[b][c] <= '0;
                end
            end
        end else if (in_fire) begin
            bank[wr_bank][wr_cnt] <= in_col;
        end
    end

    // Fill side: column counter, bank pointer and per-block direction captured on the first beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            mode    <= '0;
        end else if (in_fire) begin
            if (wr_cnt == '0) mode[wr_bank] <= in_inv;
            if (wr_cnt == LAST) begin
                wr_cnt  <= '0;
                wr_bank <= !wr_bank;
            end else begin
                wr_cnt <= wr_cnt + CW'(1);
            end
        end
    end

    // Drain side: column counter and bank pointer advance on each accepted output beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (out_fire) begin
            if (rd_cnt == LAST) begin
                rd_cnt  <= '0;
                rd_bank <= !rd_bank;
            end else begin
                rd_cnt <= rd_cnt + CW'(1);
            end
        end
    end

    // Fill completion and drain completion always target different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (in_fire && wr_cnt == LAST)   full_nxt[wr_bank] = 1'b1;
        if (out_fire && rd_cnt == LAST)  full_nxt[rd_bank] = 1'b0;
    end

    // Bank occupancy flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full <= '0;
        end else begin
            full <= full_nxt;
        end
    end

    // Gather each row's byte from its rotated source column of the draining bank.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            shifted[8*r +: 8] = bank[rd_bank][src_idx(rd_cnt, row_ofs(r), mode[rd_bank])][8*r +: 8];
        end
    end

    // Outputs are zero whenever no block is being presented.
    always_comb begin
        out_col  = out_valid ? shifted : 32'h0;
        out_last = out_valid && (rd_cnt == LAST);
    end

endmodule

// File: tb/tb_aes_srow_stream.sv
// Bench for aes_srow_stream: NB=4 and NB=8 instances, directed vectors plus randomized streams.
// Each cycle the bench predicts in_ready/out_valid from a block-level scoreboard and checks every output beat.
// Backpressure and stalls are exercised with random out_ready and in_valid patterns.
module tb_aes_srow_stream;

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid_4, in_ready_4, in_inv_4, out_valid_4, out_ready_4, out_last_4;
    logic [31:0] in_col_4, out_col_4;
    logic        in_valid_8, in_ready_8, in_inv_8, out_valid_8, out_ready_8, out_last_8;
    logic [31:0] in_col_8, out_col_8;

    int tests = 0;
    int fails = 0;

    logic [32:0] exp_q[$];    // {last, col} expected output beats, in order
    logic [31:0] cur_cols[$]; // columns of the block currently being filled
    logic        cur_inv;
    logic [31:0] dir_q[$];    // hand-written expected columns overriding the model

    aes_srow_stream #(.NB(4)) dut4 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_4), .in_ready(in_ready_4), .in_col(in_col_4), .in_inv(in_inv_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4), .out_col(out_col_4), .out_last(out_last_4)
    );

    aes_srow_stream #(.NB(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .in_col(in_col_8), .in_inv(in_inv_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8), .out_col(out_col_8), .out_last(out_last_8)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int row_shift(input int nb, input int r);
        if (r == 0) return 0;
        if (r == 1) return 1;
        if (r == 2) return (nb == 8) ? 3 : 2;
        return (nb == 8) ? 4 : 3;
    endfunction

    function automatic logic [31:0] seq_col(input int base, input int j);
        logic [31:0] c;
        for (int r = 0; r < 4; r++) c[8*r +: 8] = 8'(base + 4*j + r);
        return c;
    endfunction

    // Rotate each row of the completed block (left for forward, right for inverse).
    task automatic build_block(input int nb);
        logic [31:0] col, src;
        int sh;
        for (int j = 0; j < nb; j++) begin
            if (dir_q.size() > 0) begin
                col = dir_q.pop_front();
            end else begin
                col = '0;
                for (int r = 0; r < 4; r++) begin
                    sh  = cur_inv ? (nb - row_shift(nb, r)) : row_shift(nb, r);
                    src = cur_cols[(j + sh) % nb];
                    col[8*r +: 8] = src[8*r +: 8];
                end
            end
            exp_q.push_back({(j == nb - 1), col});
        end
    endtask

    // One clock cycle: drive inputs, check handshake predictions and any accepted output beat.
    task automatic step(input int nb, input logic iv, input logic [31:0] col,
                        input logic inv, input logic ordy);
        logic        rdy, ov, ol;
        logic [31:0] oc;
        logic [32:0] e;
        int          pend;
        @(negedge clock);
        if (nb == 8) begin
            in_valid_8 = iv; in_col_8 = col; in_inv_8 = inv; out_ready_8 = ordy;
        end else begin
            in_valid_4 = iv; in_col_4 = col; in_inv_4 = inv; out_ready_4 = ordy;
        end
        #1;
        if (nb == 8) begin
            rdy = in_ready_8; ov = out_valid_8; oc = out_col_8; ol = out_last_8;
        end else begin
            rdy = in_ready_4; ov = out_valid_4; oc = out_col_4; ol = out_last_4;
        end
        pend = (exp_q.size() + nb - 1) / nb;
        check("in_ready", 32'(rdy), 32'(pend < 2));
        check("out_valid", 32'(ov), 32'(exp_q.size() > 0));
        if (ov && ordy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_col", oc, e[31:0]);
            check("out_last", 32'(ol), 32'(e[32]));
        end
        if (iv && rdy) begin
            if (cur_cols.size() == 0) cur_inv = inv;
            cur_cols.push_back(col);
            if (cur_cols.size() == nb) begin
                build_block(nb);
                cur_cols.delete();
            end
        end
    endtask

    task automatic drain(input int nb);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) step(nb, 1'b0, 32'h0, 1'b0, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_seq(input int nb, input int base, input logic inv);
        for (int j = 0; j < nb; j++) step(nb, 1'b1, seq_col(base, j), inv, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        in_valid_4 = 1'b0; out_ready_4 = 1'b1;
        in_valid_8 = 1'b0; out_ready_8 = 1'b1;
        exp_q.delete(); cur_cols.delete(); dir_q.delete();
        @(negedge clock);
        #1;
        check("rst_in_ready4", 32'(in_ready_4), 32'd1);
        check("rst_out_valid4", 32'(out_valid_4), 32'd0);
        check("rst_out_last4", 32'(out_last_4), 32'd0);
        check("rst_out_col4", out_col_4, 32'h0);
        check("rst_in_ready8", 32'(in_ready_8), 32'd1);
        check("rst_out_valid8", 32'(out_valid_8), 32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic random_phase(input int nb, input int cycles);
        for (int i = 0; i < cycles; i++)
            step(nb, ($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0));
        for (int i = 0; i < 3*nb && cur_cols.size() > 0; i++)
            step(nb, 1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        check("block_closed", 32'(cur_cols.size()), 32'd0);
        drain(nb);
    endtask

    initial begin
        reset = 1'b0;
        in_valid_4 = 1'b0; in_col_4 = '0; in_inv_4 = 1'b0; out_ready_4 = 1'b1;
        in_valid_8 = 1'b0; in_col_8 = '0; in_inv_8 = 1'b0; out_ready_8 = 1'b1;
        cur_inv = 1'b0;
        do_reset();

        // NB=4 forward, bytes 00..0F
        dir_q = '{32'h0F0A0500, 32'h030E0904, 32'h07020D08, 32'h0B06010C};
        send_seq(4, 0, 1'b0);
        drain(4);

        // NB=4 inverse, then forward on the result restores the original state
        dir_q = '{32'h070A0D00, 32'h0B0E0104, 32'h0F020508, 32'h0306090C};
        send_seq(4, 0, 1'b1);
        drain(4);
        dir_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        step(4, 1'b1, 32'h070A0D00, 1'b0, 1'b1);
        step(4, 1'b1, 32'h0B0E0104, 1'b1, 1'b1);
        step(4, 1'b1, 32'h0F020508, 1'b1, 1'b1);
        step(4, 1'b1, 32'h0306090C, 1'b1, 1'b1);
        drain(4);

        // Two blocks back-to-back, opposite directions, full throughput
        for (int j = 0; j < 8; j++) step(4, 1'b1, $urandom, (j >= 4), 1'b1);
        drain(4);

        // Downstream stalled: both banks fill, in_ready returns only after block 0 drains
        for (int j = 0; j < 8; j++) step(4, 1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        step(4, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        step(4, 1'b0, 32'h0, 1'b0, 1'b1);
        step(4, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) step(4, 1'b0, 32'h0, 1'b0, 1'b1);
        step(4, 1'b0, 32'h0, 1'b0, 1'b0);
        drain(4);

        // Reset mid-block discards the partial fill
        step(4, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b1);
        step(4, 1'b1, 32'h55555555, 1'b1, 1'b1);
        do_reset();
        dir_q = '{32'h0F0A0500, 32'h030E0904, 32'h07020D08, 32'h0B06010C};
        send_seq(4, 0, 1'b0);
        drain(4);

        // NB=8 forward, bytes 00..1F
        dir_q = '{32'h130E0500, 32'h17120904, 32'h1B160D08, 32'h1F1A110C,
                  32'h031E1510, 32'h07021914, 32'h0B061D18, 32'h0F0A011C};
        send_seq(8, 0, 1'b0);
        drain(8);

        // Randomized streams with stalls and mixed directions
        random_phase(4, 300);
        random_phase(8, 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
